maze_time_display: RTL



---
 rtl/maze_disp_pkg.sv | 28 ++
 rtl/maze_time_display_if.sv | 23 ++
 rtl/seg7_decode.sv | 21 ++
 rtl/maze_time_display.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/maze_disp_pkg.sv
// Shared constants for the maze time display: FSM encoding, glyphs and the BCD time type.
package maze_disp_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_b     = 7'h03;
  localparam logic [6:0] SEG_F     = 7'h0E;

  localparam int LST_SCAN_DEFAULT  = 49_999;
  localparam int LST_BLINK_DEFAULT = 12_499_999;

  typedef struct packed {
    logic [3:0] hun;
    logic [3:0] ten;
    logic [3:0] uni;
  } bcd_time_t;

  // Valid BCD packed hundreds-first compares the same as its numeric value.
  function automatic logic bcd_less(input bcd_time_t a, input bcd_time_t b);
    return {a.hun, a.ten, a.uni} < {b.hun, b.ten, b.uni};
  endfunction

endpackage

// File: rtl/maze_time_display_if.sv
// Timer/game-side signals into the display and the display outputs back out.
interface maze_time_display_if;
  logic [3:0] i_Sec0;
  logic [3:0] i_Sec1;
  logic [3:0] i_Sec2;
  logic       i_Running;
  logic       i_Finish;
  logic       i_ShowBest;
  logic [6:0] o_Seg;
  logic [3:0] o_Com;
  logic       o_NewBest;
  logic       o_BestValid;

  modport master (
    output i_Sec0, i_Sec1, i_Sec2, i_Running, i_Finish, i_ShowBest,
    input  o_Seg, o_Com, o_NewBest, o_BestValid
  );

  modport slave (
    input  i_Sec0, i_Sec1, i_Sec2, i_Running, i_Finish, i_ShowBest,
    output o_Seg, o_Com, o_NewBest, o_BestValid
  );
endinterface

// File: rtl/seg7_decode.sv
// BCD digit to active-low 7-segment code; codes 10-15 render as all segments off.
module seg7_decode (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    case (bcd)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  end
endmodule

// File: rtl/maze_time_display.sv
// Game-phase tracking, frozen/best time and 4-digit multiplexed display driver.
// Define MAZE_HOLD_BLINK_EN to blink the frozen time while in HOLD.
module maze_time_display
  import maze_disp_pkg::*;
#(
  parameter int LST_SCAN = LST_SCAN_DEFAULT
`ifdef MAZE_HOLD_BLINK_EN
  , parameter int LST_BLINK = LST_BLINK_DEFAULT
`endif
) (
  input logic           i_Clk,
  input logic           i_Rst,
  maze_time_display_if.slave bus
);
  localparam int SW = (LST_SCAN > 0) ? $clog2(LST_SCAN + 1) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(LST_SCAN);

  logic [1:0]    state_reg, state_next;
  logic          latch_en, take_best;
  logic          run_prev_reg;
  bcd_time_t     live, frozen_reg, best_reg, src;
  logic          best_valid_reg, new_best_reg;
  logic [SW-1:0] scan_cnt_reg;
  logic [1:0]    digit_idx_reg;
  logic [6:0]    seg_reg, seg_next, glyph3;
  logic [3:0]    com_reg;
  logic          dashes, hide_time;
  logic [3:0]    src_digit [3];
  logic [6:0]    dec_seg   [3];
  logic [6:0]    time_seg  [3];
  logic [2:0]    blank_lz;

  assign live = {bus.i_Sec2, bus.i_Sec1, bus.i_Sec0};

  always_comb begin
    state_next = state_reg;
    latch_en   = 1'b0;
    case (state_reg)
      ST_IDLE: if (bus.i_Running) state_next = ST_RUN;
      ST_RUN: begin
        if (bus.i_Finish) begin
          state_next = ST_HOLD;
          latch_en   = 1'b1;
        end else if (!bus.i_Running) begin
          state_next = ST_IDLE;
        end
      end
      ST_HOLD: if (bus.i_Running && !run_prev_reg) state_next = ST_RUN;
      default: state_next = ST_IDLE;
    endcase
  end

  assign take_best = latch_en && (!best_valid_reg || bcd_less(live, best_reg));

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_reg      <= ST_IDLE;
      run_prev_reg   <= 1'b0;
      frozen_reg     <= '0;
      best_reg       <= '0;
      best_valid_reg <= 1'b0;
      new_best_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      run_prev_reg <= bus.i_Running;
      new_best_reg <= take_best;
      if (latch_en) frozen_reg <= live;
      if (take_best) begin
        best_reg       <= live;
        best_valid_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      scan_cnt_reg  <= '0;
      digit_idx_reg <= 2'd0;
    end else if (scan_cnt_reg == SCAN_LAST) begin
      scan_cnt_reg  <= '0;
      digit_idx_reg <= digit_idx_reg + 2'd1;
    end else begin
      scan_cnt_reg  <= scan_cnt_reg + 1'b1;
    end
  end

`ifdef MAZE_HOLD_BLINK_EN
  localparam int BW = (LST_BLINK > 0) ? $clog2(LST_BLINK + 1) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(LST_BLINK);

  logic [BW-1:0] blink_cnt_reg;
  logic          blink_off_reg;

  // Restarting on every state change makes each HOLD entry begin in the lit phase.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      blink_cnt_reg <= '0;
      blink_off_reg <= 1'b0;
    end else if (state_next != state_reg || state_reg != ST_HOLD) begin
      blink_cnt_reg <= '0;
      blink_off_reg <= 1'b0;
    end else if (blink_cnt_reg == BLINK_LAST) begin
      blink_cnt_reg <= '0;
      blink_off_reg <= ~blink_off_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + 1'b1;
    end
  end

  assign hide_time = blink_off_reg && !bus.i_ShowBest;
`else
  assign hide_time = 1'b0;
`endif

  always_comb begin
    src    = live;
    glyph3 = SEG_BLANK;
    dashes = 1'b0;
    if (bus.i_ShowBest) begin
      glyph3 = SEG_b;
      if (best_valid_reg) src = best_reg;
      else                dashes = 1'b1;
    end else if (state_reg == ST_HOLD) begin
      src    = frozen_reg;
      glyph3 = SEG_F;
    end
  end

  assign src_digit[0] = src.uni;
  assign src_digit[1] = src.ten;
  assign src_digit[2] = src.hun;
  assign blank_lz = {src.hun == 4'd0, (src.hun == 4'd0) && (src.ten == 4'd0), 1'b0};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_digit
      seg7_decode u_dec (
        .bcd (src_digit[gi]),
        .seg (dec_seg[gi])
      );
      assign time_seg[gi] = dashes                       ? SEG_DASH  :
                            (blank_lz[gi] || hide_time)  ? SEG_BLANK : dec_seg[gi];
    end
  endgenerate

  always_comb begin
    case (digit_idx_reg)
      2'd0:    seg_next = time_seg[0];
      2'd1:    seg_next = time_seg[1];
      2'd2:    seg_next = time_seg[2];
      default: seg_next = glyph3;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      seg_reg <= SEG_BLANK;
      com_reg <= 4'b1110;
    end else begin
      seg_reg <= seg_next;
      com_reg <= ~(4'b0001 << digit_idx_reg);
    end
  end

  assign bus.o_Seg       = seg_reg;
  assign bus.o_Com       = com_reg;
  assign bus.o_NewBest   = new_best_reg;
  assign bus.o_BestValid = best_valid_reg;

endmodule
